// File: rtl/master_bus_pkg.sv
// Shared types and constants for the master-side system bus ports.
package master_bus_pkg;

    localparam int DEFAULT_DATA_LEN = 8;

    // Bus instruction encoding decoded by the wrapper that raises start.
    localparam logic [1:0] BUS_INSTR_READ = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HANDSHAKE = 2'd1,
        ST_RECEIVE   = 2'd2,
        ST_DONE      = 2'd3
    } rx_state_t;

    // Destination bit of the cnt-th serial bit of a len-bit word.
    function automatic int unsigned bit_pos(input logic lsb_first, input int unsigned cnt,
                                            input int unsigned len);
        return lsb_first ? cnt : (len - 1 - cnt);
    endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous show-ahead FIFO for received words; DEPTH must be a power of two.
module rx_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the address bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/master_rx_burst.sv
// Master-side burst read port: handshake, serial deserialise, word FIFO, timeout abort.
// Define RX_PARITY_EN to accept a trailing even-parity bit per word and expose parity_err.
module master_rx_burst
    import master_bus_pkg::*;
#(
    parameter int DATA_LEN   = DEFAULT_DATA_LEN,
    parameter int BURST_W    = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BURST_W-1:0]  burst_num,
    input  logic                lsb_first,
    input  logic                slave_valid,
    input  logic                rx_data,
    output logic                master_ready,
    output logic [DATA_LEN-1:0] data,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                rx_done,
    output logic                rx_busy,
    output logic                timeout_err
`ifdef RX_PARITY_EN
    ,
    output logic                parity_err
`endif
);

`ifdef RX_PARITY_EN
    localparam int BITS_PER_WORD = DATA_LEN + 1;
`else
    localparam int BITS_PER_WORD = DATA_LEN;
`endif
    localparam int BC_W  = $clog2(BITS_PER_WORD);
    localparam int IDX_W = $clog2(DATA_LEN);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(BITS_PER_WORD - 1);
    localparam logic [BC_W-1:0]  BIT_ONE  = BC_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [BURST_W:0] WORD_ONE = (BURST_W + 1)'(1);

    rx_state_t           state;
    rx_state_t           state_next;
    logic [BURST_W:0]    burst_total;
    logic [BURST_W:0]    word_cnt;
    logic [BC_W-1:0]     bit_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                lsb_lat;
    logic [DATA_LEN-1:0] word_reg;
    logic [DATA_LEN-1:0] word_assembled;
    logic [DATA_LEN-1:0] push_word;
    logic [IDX_W-1:0]    bit_idx;
    logic                data_phase;
    logic                start_ok;
    logic                hs_accept;
    logic                bit_accept;
    logic                idle_cycle;
    logic                tmo_expire;
    logic                word_end;
    logic                burst_end;
    logic                fifo_full;
    logic                fifo_empty;

    assign master_ready = (state == ST_HANDSHAKE) || ((state == ST_RECEIVE) && !fifo_full);
    assign start_ok     = (state == ST_IDLE) && start;
    assign hs_accept    = (state == ST_HANDSHAKE) && slave_valid;
    assign bit_accept   = (state == ST_RECEIVE) && slave_valid && master_ready;
    // master_ready is only ever high in HANDSHAKE/RECEIVE, so no extra state qualifier.
    assign idle_cycle   = master_ready && !slave_valid;
    assign tmo_expire   = idle_cycle && (tmo_cnt == TMO_LAST);
    assign word_end     = bit_accept && (bit_cnt == BIT_LAST);
    assign burst_end    = word_end && ((word_cnt + WORD_ONE) == burst_total);

    assign bit_idx = IDX_W'(bit_pos(lsb_lat, int'(bit_cnt), DATA_LEN));

`ifdef RX_PARITY_EN
    // The final slot of each word carries parity, not data.
    assign data_phase = (bit_cnt != BIT_LAST);
    assign push_word  = word_reg;
`else
    assign data_phase = 1'b1;
    assign push_word  = word_assembled;
`endif

    always_comb begin
        word_assembled = word_reg;
        if (data_phase) word_assembled[bit_idx] = rx_data;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next; a missing branch would infer a latch.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_HANDSHAKE;
            end
            ST_HANDSHAKE: begin
                if (slave_valid)     state_next = ST_RECEIVE;
                else if (tmo_expire) state_next = ST_IDLE;
            end
            ST_RECEIVE: begin
                if (burst_end)       state_next = ST_DONE;
                else if (tmo_expire) state_next = ST_IDLE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            burst_total <= '0;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            lsb_lat     <= 1'b0;
            word_reg    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                burst_total <= {1'b0, burst_num} + WORD_ONE;
                lsb_lat     <= lsb_first;
                word_cnt    <= '0;
                bit_cnt     <= '0;
                tmo_cnt     <= '0;
                word_reg    <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (hs_accept || bit_accept || tmo_expire) tmo_cnt <= '0;
                else if (idle_cycle)                       tmo_cnt <= tmo_cnt + TMO_ONE;

                if (tmo_expire) begin
                    // Abort drops the partial word; words already pushed stay queued.
                    timeout_err <= 1'b1;
                    bit_cnt     <= '0;
                end else if (bit_accept) begin
                    word_reg <= word_assembled;
                    bit_cnt  <= word_end ? '0 : bit_cnt + BIT_ONE;
                    if (word_end) word_cnt <= word_cnt + WORD_ONE;
                end
            end
        end
    end

`ifdef RX_PARITY_EN
    logic parity_bad;

    // Even parity: the parity bit equals the XOR of the data bits.
    assign parity_bad = word_end && (rx_data != ^word_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           parity_err <= 1'b0;
        else if (start_ok)   parity_err <= 1'b0;
        else if (parity_bad) parity_err <= 1'b1;
    end
`endif

    rx_word_fifo #(
        .WIDTH (DATA_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (word_end),
        .push_data (push_word),
        .pop       (data_ready),
        .pop_data  (data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_valid = !fifo_empty;
    assign rx_done    = (state == ST_DONE);
    assign rx_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_master_rx_burst.sv
// Directed + randomized bench for master_rx_burst; expected words come from a bit-sequence model.
module tb_master_rx_burst;

    localparam int DATA_LEN   = 8;
    localparam int BURST_W    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;
    localparam int WAIT_MAX   = 200;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [BURST_W-1:0]  burst_num;
    logic                lsb_first;
    logic                slave_valid;
    logic                rx_data;
    logic                master_ready;
    logic [DATA_LEN-1:0] data;
    logic                data_valid;
    logic                data_ready;
    logic                rx_done;
    logic                rx_busy;
    logic                timeout_err;
`ifdef RX_PARITY_EN
    logic                parity_err;
`endif

    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;
    logic rand_ready = 1'b0;

    logic [DATA_LEN-1:0] exp_q[$];
    logic [DATA_LEN-1:0] got_q[$];

    always #5 clk = ~clk;

    master_rx_burst #(
        .DATA_LEN   (DATA_LEN),
        .BURST_W    (BURST_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .burst_num    (burst_num),
        .lsb_first    (lsb_first),
        .slave_valid  (slave_valid),
        .rx_data      (rx_data),
        .master_ready (master_ready),
        .data         (data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .rx_done      (rx_done),
        .rx_busy      (rx_busy),
        .timeout_err  (timeout_err)
`ifdef RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Word value from the transmitted bit sequence: seq[i] is the i-th bit on the wire.
    function automatic logic [DATA_LEN-1:0] model_word(input logic [DATA_LEN-1:0] seq, input logic lsb);
        int unsigned v = 0;
        for (int i = 0; i < DATA_LEN; i++)
            if (seq[i]) v += lsb ? (32'd1 << i) : (32'd1 << (DATA_LEN - 1 - i));
        return DATA_LEN'(v);
    endfunction

    // One clock: record a pop that the coming edge will perform, then move to the next falling edge.
    task automatic tick();
        if (rand_ready) data_ready = 1'($urandom_range(0, 1));
        if (data_valid && data_ready) got_q.push_back(data);
        @(negedge clk);
        if (rx_done) done_cnt++;
    endtask

    task automatic send_bit(input logic b);
        int waited = 0;
        slave_valid = 1'b1;
        rx_data     = b;
        while (!master_ready && waited < WAIT_MAX) begin
            tick();
            waited++;
        end
        if (waited >= WAIT_MAX) check("ready_wait_expired", 32'(waited), 32'(0));
        tick();
        slave_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_LEN-1:0] seq, input int gap_max);
        for (int i = 0; i < DATA_LEN; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            send_bit(seq[i]);
        end
`ifdef RX_PARITY_EN
        send_bit(^seq);
`endif
    endtask

    task automatic start_burst(input logic [BURST_W-1:0] bn, input logic lsb);
        done_cnt  = 0;
        start     = 1'b1;
        burst_num = bn;
        lsb_first = lsb;
        tick();
        start       = 1'b0;
        slave_valid = 1'b1;
        tick();
        slave_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b0;
        data_ready = 1'b1;
        while (data_valid && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("drain_expired", 32'(n), 32'(0));
        data_ready = 1'b0;
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_LEN-1:0] seq;
        logic                lsb;

        reset       = 1'b1;
        start       = 1'b0;
        burst_num   = '0;
        lsb_first   = 1'b0;
        slave_valid = 1'b0;
        rx_data     = 1'b0;
        data_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_master_ready", 32'(master_ready), 32'(0));
        check("rst_data", 32'(data), 32'(0));
        check("rst_data_valid", 32'(data_valid), 32'(0));
        check("rst_rx_done", 32'(rx_done), 32'(0));
        check("rst_rx_busy", 32'(rx_busy), 32'(0));
        check("rst_timeout_err", 32'(timeout_err), 32'(0));
        reset = 1'b0;
        tick();

        // Single word, LSB first: wire order 1,0,1,1,0,0,1,0.
        seq = 8'b0100_1101;
        start_burst('0, 1'b1);
        check("t1_busy", 32'(rx_busy), 32'(1));
        for (int i = 0; i < DATA_LEN; i++) begin
            if (i == DATA_LEN - 1) check("t1_valid_early", 32'(data_valid), 32'(0));
            send_bit(seq[i]);
        end
`ifdef RX_PARITY_EN
        check("t1_valid_before_parity", 32'(data_valid), 32'(0));
        send_bit(^seq);
`endif
        check("t1_valid", 32'(data_valid), 32'(1));
        check("t1_data", 32'(data), 32'h4D);
        check("t1_done", 32'(rx_done), 32'(1));
        tick();
        check("t1_done_fall", 32'(rx_done), 32'(0));
        check("t1_busy_fall", 32'(rx_busy), 32'(0));
        check("t1_done_count", 32'(done_cnt), 32'(1));
        exp_q.push_back(model_word(seq, 1'b1));
        drain();
        compare_words("t1");

        // Same wire bits, MSB first.
        data_ready = 1'b1;
        start_burst('0, 1'b0);
        send_word(seq, 0);
        check("t2_data", 32'(data), 32'hB2);
        exp_q.push_back(model_word(seq, 1'b0));
        tick();
        drain();
        compare_words("t2");
        check("t2_done_count", 32'(done_cnt), 32'(1));

        // Back-pressure: six words into a four-deep FIFO with the consumer stalled.
        data_ready = 1'b0;
        start_burst(BURST_W'(5), 1'b1);
        for (int w = 0; w < 4; w++) begin
            seq = DATA_LEN'($urandom);
            exp_q.push_back(model_word(seq, 1'b1));
            send_word(seq, 0);
        end
        check("t3_ready_full", 32'(master_ready), 32'(0));
        repeat (TIMEOUT + 4) tick();
        check("t3_ready_held", 32'(master_ready), 32'(0));
        check("t3_busy_held", 32'(rx_busy), 32'(1));
        check("t3_no_timeout", 32'(timeout_err), 32'(0));
        data_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            seq = DATA_LEN'($urandom);
            exp_q.push_back(model_word(seq, 1'b1));
            send_word(seq, 0);
        end
        check("t3_done", 32'(rx_done), 32'(1));
        tick();
        drain();
        compare_words("t3");
        check("t3_done_count", 32'(done_cnt), 32'(1));

        // Random gaps shorter than the timeout, random consumer stalls, a start pulse mid-burst.
        lsb = 1'($urandom_range(0, 1));
        rand_ready = 1'b1;
        start_burst(BURST_W'(3), lsb);
        for (int w = 0; w < 4; w++) begin
            seq = DATA_LEN'($urandom);
            exp_q.push_back(model_word(seq, lsb));
            send_word(seq, TIMEOUT - 2);
            if (w == 0) begin
                start     = 1'b1;
                burst_num = '0;
                tick();
                start = 1'b0;
            end
        end
        tick();
        check("t4_no_timeout", 32'(timeout_err), 32'(0));
        check("t4_idle", 32'(rx_busy), 32'(0));
        drain();
        compare_words("t4");
        check("t4_done_count", 32'(done_cnt), 32'(1));

        // Timeout after three bits of the second word.
        data_ready = 1'b0;
        start_burst(BURST_W'(2), 1'b1);
        seq = DATA_LEN'($urandom);
        exp_q.push_back(model_word(seq, 1'b1));
        send_word(seq, 0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (TIMEOUT - 1) tick();
        check("t5_busy_before", 32'(rx_busy), 32'(1));
        check("t5_err_before", 32'(timeout_err), 32'(0));
        tick();
        check("t5_idle", 32'(rx_busy), 32'(0));
        check("t5_err", 32'(timeout_err), 32'(1));
        check("t5_ready", 32'(master_ready), 32'(0));
        check("t5_no_done", 32'(done_cnt), 32'(0));
        check("t5_fifo_valid", 32'(data_valid), 32'(1));
        check("t5_fifo_head", 32'(data), 32'(model_word(seq, 1'b1)));
        start_burst('0, 1'b0);
        check("t5_err_cleared", 32'(timeout_err), 32'(0));
        seq = DATA_LEN'($urandom);
        exp_q.push_back(model_word(seq, 1'b0));
        send_word(seq, 0);
        tick();
        drain();
        compare_words("t5");
        check("t5_done_count", 32'(done_cnt), 32'(1));

        // Asynchronous reset in the middle of the second word.
        start_burst(BURST_W'(3), 1'b1);
        send_word(DATA_LEN'($urandom), 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        check("t6_valid_before", 32'(data_valid), 32'(1));
        reset = 1'b1;
        #1;
        check("t6_master_ready", 32'(master_ready), 32'(0));
        check("t6_data", 32'(data), 32'(0));
        check("t6_data_valid", 32'(data_valid), 32'(0));
        check("t6_rx_busy", 32'(rx_busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t6_valid_after", 32'(data_valid), 32'(0));
        check("t6_busy_after", 32'(rx_busy), 32'(0));
        exp_q.delete();
        got_q.delete();

        // Maximum burst_num: 2^BURST_W words with random consumer stalls.
        lsb = 1'($urandom_range(0, 1));
        rand_ready = 1'b1;
        start_burst('1, lsb);
        for (int w = 0; w < (1 << BURST_W); w++) begin
            seq = DATA_LEN'($urandom);
            exp_q.push_back(model_word(seq, lsb));
            send_word(seq, 3);
        end
        tick();
        drain();
        compare_words("t7");
        check("t7_done_count", 32'(done_cnt), 32'(1));
        check("t7_no_timeout", 32'(timeout_err), 32'(0));

`ifdef RX_PARITY_EN
        check("t8_parity_clean", 32'(parity_err), 32'(0));
        start_burst('0, 1'b1);
        seq = DATA_LEN'($urandom);
        for (int i = 0; i < DATA_LEN; i++) send_bit(seq[i]);
        send_bit(~(^seq));
        check("t8_parity_err", 32'(parity_err), 32'(1));
        check("t8_valid", 32'(data_valid), 32'(1));
        check("t8_data", 32'(data), 32'(model_word(seq, 1'b1)));
        tick();
        start_burst('0, 1'b1);
        check("t8_parity_cleared", 32'(parity_err), 32'(0));
        send_word(seq, 0);
        tick();
        drain();
        got_q.delete();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/master_rx_burst.md
Name: master_rx_burst

Overview:
- Parametrised master-side read port for the system bus.
- Handshakes with a slave, then deserialises a burst of words from a 1-bit serial line.
- Uses per-bit valid/ready flow control and buffers complete words in a small FIFO for the downstream consumer (LCD/display logic, master out).
- Adds selectable bit order, back-pressure and a timeout abort.

Parameters:
- DATA_LEN, 8, bits per word.
- BURST_W, 12, width of burst_num.
- FIFO_DEPTH, 4, word buffer depth; power of 2, at least 2.
- TIMEOUT, 255, idle cycles without an accepted bit before abort; at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin read transaction; sampled in IDLE only.
- burst_num  in  BURST_W  extra words after the first (total = burst_num+1); latched at start.
- lsb_first  in  1  1: first bit goes to data[0]; 0: first bit goes to data[DATA_LEN-1]; latched at start.
- slave_valid  in  1  slave drives a valid handshake or bit.
- rx_data  in  1  serial data from slave.
- master_ready  out  1  master accepts handshake or bit this cycle.
- data  out  DATA_LEN  FIFO head word.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer pops the head when data_valid=1.
- rx_done  out  1  1-cycle pulse: full burst received.
- rx_busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky abort flag; cleared on next accepted start.

Behaviour:
- Reset: state=IDLE; FIFO emptied.
  - All outputs 0: master_ready, data, data_valid, rx_done, rx_busy, timeout_err.
  - All counters 0.
- States: IDLE, HANDSHAKE, RECEIVE, DONE.
- IDLE:
  - master_ready=0.
  - On start=1: latch burst_num and lsb_first, clear timeout_err, clear counters, go to HANDSHAKE.
- HANDSHAKE:
  - master_ready=1.
  - slave_valid=1 goes to RECEIVE; no data bit is taken that cycle.
- RECEIVE:
  - master_ready = !fifo_full.
  - A bit is accepted only when slave_valid && master_ready. It is placed per latched bit order and bit_cnt increments.
  - On accepting bit DATA_LEN-1, the assembled word (including that bit) is pushed the same cycle and bit_cnt returns to 0.
  - The word counter has BURST_W+1 bits. When the pushed word is number burst_num+1, go to DONE.
  - Partial words may stall mid-word while master_ready=0; the slave must hold rx_data.
- DONE:
  - rx_done=1 for exactly one cycle, then IDLE.
- Latency: a word appears at data/data_valid the cycle after its last bit is accepted, if the FIFO was empty.
- FIFO:
  - Show-ahead: data is valid whenever data_valid=1.
  - Pop on data_valid && data_ready.
  - Simultaneous push and pop when full is not possible, because master_ready=0 when full.
  - Simultaneous push and pop at any other occupancy keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Timeout:
  - In HANDSHAKE/RECEIVE, a counter increments on each cycle with master_ready=1 && slave_valid=0.
  - The counter resets on any accepted bit or handshake.
  - Cycles with master_ready=0 do not count.
  - When the counter reaches TIMEOUT: set timeout_err, discard the partial word, go to IDLE, no rx_done. Already-pushed words stay in the FIFO.
- Other conditions:
  - start outside IDLE is ignored.
  - The FIFO may hold words when returning to IDLE; a new start is accepted regardless of FIFO content.
  - burst_num=0 gives one word. burst_num=all-ones gives 2^BURST_W words.
  - Reset mid-transaction aborts immediately and flushes the FIFO.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - After bit DATA_LEN-1 of each word, one additional even-parity bit is accepted under the same valid/ready rule.
  - The word is pushed on acceptance of the parity bit.
  - A mismatch sets output parity_err (1-bit, sticky, cleared on start); the word is still pushed.
- Undefined: no parity bit, and no parity_err port.

Decomposition:
- Package master_bus_pkg holds:
  - the rx state enum;
  - the bus instruction encodings (READ = 2'b11), used by the wrapper that generates start;
  - a shared default DATA_LEN constant.
- Sub-module rx_word_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, and ports push/pop/full/empty.

Test Plan:
- Single word: burst_num=0, lsb_first=1, bits 1,0,1,1,0,0,1,0 -> data=8'h4D; data_valid 1 cycle after last bit; rx_done pulses once; rx_busy falls.
- Bit order: same bits with lsb_first=0 -> data=8'hB2.
- Back-pressure: burst_num=5, data_ready=0, FIFO_DEPTH=4 -> master_ready drops after 4th word. Then raise data_ready -> all 6 words arrive in order, none lost; rx_done after 6th.
- Stalls: slave_valid toggled low randomly but for fewer than TIMEOUT cycles -> same words as ungapped run; timeout_err=0.
- Timeout: TIMEOUT=16, slave_valid held low for 16 cycles after 3 bits -> timeout_err=1, state IDLE, no rx_done, FIFO unchanged. Next start clears timeout_err.
- Reset mid-burst (word 2 of 4) -> all outputs 0 next cycle, data_valid=0; start ignored while busy. With RX_PARITY_EN: a wrong parity bit sets parity_err and the word is still delivered.
